// File: rtl/zone_bl_stat.sv
// Local-dimming zone statistics: tiles a cropped window into zones, computes exact
// per-zone max/mean and streams one backlight value per zone in raster order.
module zone_bl_stat #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 800,
  parameter int ZONE_COLS = 24,
  parameter int ZONE_ROWS = 15,
  parameter int ZONE_W    = 53,
  parameter int ZONE_H    = 53,
  parameter int X_OFFSET  = 4,
  parameter int Y_OFFSET  = 3,
  parameter int GRAY_W    = 8,
  parameter int IIR_SHIFT = 2,
  localparam int NZ       = ZONE_COLS * ZONE_ROWS,
  localparam int IDX_W    = (NZ > 1) ? $clog2(NZ) : 1
) (
  input  logic              i_pix_clk,
  input  logic              rst_n,
  input  logic              data_de,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  input  logic [GRAY_W-1:0] data_gray,
  input  logic              frame_start,
  input  logic [1:0]        gray_mode,
  input  logic [GRAY_W-1:0] diff_thr,
  output logic [IDX_W-1:0]  o_zone_idx,
  output logic [GRAY_W-1:0] o_zone_val,
  output logic              o_zone_valid,
  output logic              o_frame_done
);

  localparam int AREA      = ZONE_W * ZONE_H;
  localparam int SUM_W     = GRAY_W + $clog2(AREA);
  localparam int COL_W     = (ZONE_COLS > 1) ? $clog2(ZONE_COLS) : 1;
  localparam int X_END_RAW = X_OFFSET + ZONE_COLS * ZONE_W;
  localparam int Y_END_RAW = Y_OFFSET + ZONE_ROWS * ZONE_H;
  localparam int X_END     = (X_END_RAW < H_ACTIVE) ? X_END_RAW : H_ACTIVE;
  localparam int Y_END     = (Y_END_RAW < V_ACTIVE) ? Y_END_RAW : V_ACTIVE;

  localparam logic [10:0]       X_LO     = 11'(X_OFFSET);
  localparam logic [10:0]       X_HI     = 11'(X_END);
  localparam logic [10:0]       Y_LO     = 11'(Y_OFFSET);
  localparam logic [10:0]       Y_HI     = 11'(Y_END);
  localparam logic [10:0]       ZW11     = 11'(ZONE_W);
  localparam logic [10:0]       ZH11     = 11'(ZONE_H);
  localparam logic [10:0]       ZC11     = 11'(ZONE_COLS);
  localparam logic [10:0]       ZW_M1    = 11'(ZONE_W - 1);
  localparam logic [10:0]       ZH_M1    = 11'(ZONE_H - 1);
  localparam logic [SUM_W-1:0]  AREA_S   = SUM_W'(AREA);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NZ - 1);

  function automatic logic [GRAY_W-1:0] max_g(input logic [GRAY_W-1:0] a,
                                              input logic [GRAY_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Weighted blend toward mean when the zone has a bright outlier, toward max otherwise.
  function automatic logic [GRAY_W-1:0] blend(input logic [GRAY_W-1:0] mx,
                                              input logic [GRAY_W-1:0] mn,
                                              input logic              hi);
    logic [GRAY_W+1:0] a, b, acc;
    a   = hi ? {2'b00, mx} : {2'b00, mn};
    b   = hi ? {2'b00, mn} : {2'b00, mx};
    acc = a + (b << 1) + b;
    return acc[GRAY_W+1:2];
  endfunction

  function automatic logic [GRAY_W-1:0] iir_step(input logic [GRAY_W-1:0] b,
                                                 input logic [GRAY_W-1:0] h);
    logic signed [GRAY_W+1:0] bs, hs, diff;
    bs   = signed'({2'b00, b});
    hs   = signed'({2'b00, h});
    diff = bs - hs;
    return GRAY_W'(hs + (diff >>> IIR_SHIFT));
  endfunction

  logic [GRAY_W-1:0] seg_max;
  logic [SUM_W-1:0]  seg_sum;
  logic [GRAY_W-1:0] col_max [ZONE_COLS];
  logic [SUM_W-1:0]  col_sum [ZONE_COLS];
  logic [GRAY_W-1:0] hist [NZ];
  logic [1:0]        mode_q;
  logic [GRAY_W-1:0] thr_q;
  logic              vld_p0, vld_p1, vld_p2;

  logic [IDX_W-1:0]  idx_p0, idx_p1, idx_p2;
  logic [GRAY_W-1:0] max_p0, max_p1, mean_p1, val_p2;
  logic [SUM_W-1:0]  sum_p0;
  logic              hi_p1;

  logic [10:0]       xr, yr;
  logic              pix_ok, seg_start, seg_end, first_line, last_line, zone_done;
  logic [COL_W-1:0]  col_c;
  logic [IDX_W-1:0]  idx_c;
  logic [GRAY_W-1:0] cur_max, zmax, mean_c, blend_c, iir_c, res_c;
  logic [SUM_W-1:0]  gray_ext, cur_sum, zsum;
  logic              hi_c;

  // Input stage: qualify pixel, locate zone, merge into segment / column state
  assign xr         = pix_x - X_LO;
  assign yr         = pix_y - Y_LO;
  assign pix_ok     = data_de && (pix_x >= X_LO) && (pix_x < X_HI) &&
                      (pix_y >= Y_LO) && (pix_y < Y_HI);
  assign col_c      = COL_W'(xr / ZW11);
  assign idx_c      = IDX_W'((yr / ZH11) * ZC11 + (xr / ZW11));
  assign seg_start  = (xr % ZW11) == 11'd0;
  assign seg_end    = (xr % ZW11) == ZW_M1;
  assign first_line = (yr % ZH11) == 11'd0;
  assign last_line  = (yr % ZH11) == ZH_M1;
  assign zone_done  = pix_ok && seg_end && last_line;

  assign gray_ext = SUM_W'(data_gray);
  assign cur_max  = seg_start ? data_gray : max_g(seg_max, data_gray);
  assign cur_sum  = seg_start ? gray_ext : seg_sum + gray_ext;
  assign zmax     = first_line ? cur_max : max_g(col_max[col_c], cur_max);
  assign zsum     = first_line ? cur_sum : col_sum[col_c] + cur_sum;

  // p0 -> p1: exact mean by constant divide, outlier decision
  assign mean_c = GRAY_W'(sum_p0 / AREA_S);
  assign hi_c   = {1'b0, max_p0} > ({1'b0, mean_c} + {1'b0, thr_q});

  // p1 -> p2: mode selection, temporal filter against zone history
  assign blend_c = blend(max_p1, mean_p1, hi_p1);
  assign iir_c   = iir_step(blend_c, hist[idx_p1]);

  always_comb begin
    res_c = max_p1;
    case (mode_q)
      2'b00:   res_c = max_p1;
      2'b01:   res_c = mean_p1;
      2'b10:   res_c = blend_c;
      default: res_c = iir_c;
    endcase
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_max      <= '0;
      seg_sum      <= '0;
      mode_q       <= '0;
      thr_q        <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      o_zone_idx   <= '0;
      o_zone_val   <= '0;
      o_zone_valid <= 1'b0;
      o_frame_done <= 1'b0;
      for (int i = 0; i < ZONE_COLS; i++) begin
        col_max[i] <= '0;
        col_sum[i] <= '0;
      end
      for (int i = 0; i < NZ; i++) hist[i] <= '0;
    end else begin
      o_zone_valid <= vld_p2;
      o_frame_done <= vld_p2 && (idx_p2 == LAST_IDX);
      if (vld_p2) begin
        o_zone_idx <= idx_p2;
        o_zone_val <= val_p2;
      end
      if (frame_start) begin
        // New frame wins over any pixel or zone in flight; history survives.
        mode_q  <= gray_mode;
        thr_q   <= diff_thr;
        seg_max <= '0;
        seg_sum <= '0;
        vld_p0  <= 1'b0;
        vld_p1  <= 1'b0;
        vld_p2  <= 1'b0;
        for (int i = 0; i < ZONE_COLS; i++) begin
          col_max[i] <= '0;
          col_sum[i] <= '0;
        end
      end else begin
        vld_p0 <= zone_done;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
        if (pix_ok) begin
          seg_max <= cur_max;
          seg_sum <= cur_sum;
          if (seg_end) begin
            col_max[col_c] <= zmax;
            col_sum[col_c] <= zsum;
          end
        end
        if (vld_p1 && (mode_q == 2'b11)) hist[idx_p1] <= iir_c;
      end
    end
  end

  always_ff @(posedge i_pix_clk) begin
    idx_p0  <= idx_c;
    max_p0  <= zmax;
    sum_p0  <= zsum;
    idx_p1  <= idx_p0;
    max_p1  <= max_p0;
    mean_p1 <= mean_c;
    hi_p1   <= hi_c;
    idx_p2  <= idx_p1;
    val_p2  <= res_c;
  end

endmodule

// File: tb/tb_zone_bl_stat.sv
// Directed bench for zone_bl_stat on a reduced 16x12 raster with 3x2 zones of 4x5 pixels.
module tb_zone_bl_stat;
  localparam int H = 16, V = 12, ZC = 3, ZR = 2, ZW = 4, ZH = 5, XO = 2, YO = 1;
  localparam int GW = 8, SH = 2;
  localparam int NZ = ZC * ZR, AREA = ZW * ZH, IW = $clog2(NZ);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          data_de = 1'b0;
  logic [10:0]   pix_x = '0, pix_y = '0;
  logic [GW-1:0] data_gray = '0;
  logic          frame_start = 1'b0;
  logic [1:0]    gray_mode = '0;
  logic [GW-1:0] diff_thr = '0;
  logic [IW-1:0] o_zone_idx;
  logic [GW-1:0] o_zone_val;
  logic          o_zone_valid, o_frame_done;

  zone_bl_stat #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ZONE_COLS(ZC), .ZONE_ROWS(ZR), .ZONE_W(ZW),
    .ZONE_H(ZH), .X_OFFSET(XO), .Y_OFFSET(YO), .GRAY_W(GW), .IIR_SHIFT(SH)
  ) dut (
    .i_pix_clk(clk), .rst_n(rst_n), .data_de(data_de), .pix_x(pix_x), .pix_y(pix_y),
    .data_gray(data_gray), .frame_start(frame_start), .gray_mode(gray_mode),
    .diff_thr(diff_thr), .o_zone_idx(o_zone_idx), .o_zone_val(o_zone_val),
    .o_zone_valid(o_zone_valid), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int val;
    bit done;
    int due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   img[V][H];
  int   hist[NZ];
  int   m_mode = 0, m_thr = 0;

  // Reference: zone statistics and mode result computed from the stored image.
  function automatic int zone_model(input int z);
    int r, c, mx, sum, mean, b, res;
    r = z / ZC; c = z % ZC; mx = 0; sum = 0;
    for (int yy = 0; yy < ZH; yy++)
      for (int xx = 0; xx < ZW; xx++) begin
        int g;
        g = img[YO + r * ZH + yy][XO + c * ZW + xx];
        sum += g;
        if (g > mx) mx = g;
      end
    mean = sum / AREA;
    b = ((mx - mean) > m_thr) ? (mx + 3 * mean) >> 2 : (3 * mx + mean) >> 2;
    case (m_mode)
      0: res = mx;
      1: res = mean;
      2: res = b;
      default: begin
        res = hist[z] + ((b - hist[z]) >>> SH);
        hist[z] = res;
      end
    endcase
    return res;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (o_zone_valid) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL strobe_unexpected idx=%0d val=%0d expected no strobe", o_zone_idx, o_zone_val);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        assert (o_zone_idx === IW'(e.idx) && o_zone_val === GW'(e.val) && o_frame_done === e.done)
        else begin
          fails++;
          $error("FAIL zone_data got idx=%0d val=%0d done=%0b expected idx=%0d val=%0d done=%0b",
                 o_zone_idx, o_zone_val, o_frame_done, e.idx, e.val, e.done);
        end
        tests++;
        assert (cyc == e.due) else begin
          fails++;
          $error("FAIL zone_latency idx=%0d got cycle=%0d expected cycle=%0d", e.idx, cyc, e.due);
        end
      end
    end else begin
      tests++;
      assert (o_frame_done === 1'b0) else begin
        fails++;
        $error("FAIL frame_done_alone got=%0b expected=0", o_frame_done);
      end
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    tests++;
    assert (act == exp) else begin
      fails++;
      $error("FAIL %s got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      data_de = 1'b0; frame_start = 1'b0;
    end
  endtask

  task automatic start_frame(input int mode, input int thr);
    @(posedge clk); #1;
    data_de = 1'b0; frame_start = 1'b1;
    gray_mode = 2'(mode); diff_thr = GW'(thr);
    m_mode = mode; m_thr = thr;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Drives the first npix raster pixels; the last one may carry frame_start.
  task automatic drive_frame(input int npix, input bit fs_last, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      int x, y;
      bit fs;
      exp_t e;
      x = p % H; y = p / H;
      if (gaps && $urandom_range(0, 5) == 0) begin
        @(posedge clk); #1;
        data_de = 1'b0; frame_start = 1'b0;
        pix_x = 11'(x); pix_y = 11'(y); data_gray = 8'hFF;
      end
      fs = fs_last && (p == npix - 1);
      @(posedge clk); #1;
      data_de = 1'b1; frame_start = fs;
      pix_x = 11'(x); pix_y = 11'(y); data_gray = GW'(img[y][x]);
      if (!fs && x >= XO && x < XO + ZC * ZW && y >= YO && y < YO + ZR * ZH &&
          (x - XO) % ZW == ZW - 1 && (y - YO) % ZH == ZH - 1) begin
        e.idx  = ((y - YO) / ZH) * ZC + (x - XO) / ZW;
        e.val  = zone_model(e.idx);
        e.done = (e.idx == NZ - 1);
        e.due  = cyc + 4;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      idle(1);
      n++;
    end
    idle(6);
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL %s pending_strobes got=%0d expected=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_frame(input int mode, input int thr, input bit gaps, input string tag);
    start_frame(mode, thr);
    drive_frame(H * V, 1'b0, gaps);
    drain(tag);
  endtask

  task automatic fill_uniform(input int v);
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = v;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = int'($urandom_range(0, 255));
  endtask

  initial begin
    foreach (hist[i]) hist[i] = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(o_zone_valid), 0);
    chk("reset_idx", int'(o_zone_idx), 0);
    chk("reset_val", int'(o_zone_val), 0);
    chk("reset_done", int'(o_frame_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(NZ + 2);

    fill_uniform(100);
    run_frame(0, 0, 1'b0, "uniform100_max");

    fill_uniform(0);
    img[YO][XO] = 255;
    run_frame(0, 0, 1'b0, "dot_max");
    run_frame(1, 0, 1'b0, "dot_mean");
    run_frame(2, 200, 1'b0, "dot_blend_thr200");
    run_frame(2, 255, 1'b0, "dot_blend_thr255");

    fill_uniform(200);
    run_frame(3, 0, 1'b0, "iir_f1");
    run_frame(3, 0, 1'b1, "iir_f2");
    run_frame(3, 0, 1'b0, "iir_f3");
    fill_uniform(0);
    run_frame(3, 0, 1'b0, "iir_f4");

    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = (x < XO || x >= XO + ZC * ZW || y < YO || y >= YO + ZR * ZH) ? 255 : 10;
    run_frame(0, 0, 1'b0, "border_ignored");

    fill_rand();
    run_frame(1, 0, 1'b1, "rand_mean_gaps");
    run_frame(2, 40, 1'b1, "rand_blend_gaps");
    run_frame(0, 0, 1'b1, "rand_max_gaps");

    // Abort mid-frame at line 7: row 0 emitted, row 1 never completes.
    start_frame(0, 0);
    drive_frame(7 * H + 5, 1'b0, 1'b0);
    start_frame(0, 0);
    drain("abort_line7");
    fill_rand();
    run_frame(0, 0, 1'b0, "after_abort");

    // frame_start on the completing pixel of zone 0.
    start_frame(0, 0);
    drive_frame((YO + ZH - 1) * H + XO + ZW, 1'b1, 1'b0);
    drain("fs_with_completion");
    run_frame(1, 0, 1'b0, "after_fs_with_completion");

    // frame_start one cycle after zone 1 completes.
    start_frame(0, 0);
    drive_frame((YO + ZH - 1) * H + XO + 2 * ZW, 1'b0, 1'b0);
    void'(sb.pop_back());
    start_frame(0, 0);
    drain("fs_kills_p0");

    // frame_start two cycles after zone 2 completes.
    start_frame(0, 0);
    drive_frame((YO + ZH - 1) * H + XO + 3 * ZW, 1'b0, 1'b0);
    void'(sb.pop_back());
    idle(1);
    start_frame(0, 0);
    drain("fs_kills_p1");
    run_frame(2, 30, 1'b0, "after_fs_kills");

    // Reset mid-frame in mode 11 with zone 2 in flight.
    fill_uniform(200);
    start_frame(3, 0);
    drive_frame((YO + ZH - 1) * H + XO + 3 * ZW + 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    data_de = 1'b0;
    sb.delete();
    foreach (hist[i]) hist[i] = 0;
    m_mode = 0; m_thr = 0;
    #1;
    chk("midreset_valid", int'(o_zone_valid), 0);
    chk("midreset_idx", int'(o_zone_idx), 0);
    chk("midreset_val", int'(o_zone_val), 0);
    chk("midreset_done", int'(o_frame_done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(NZ + 2);

    fill_uniform(77);
    img[YO + 2][XO + 1] = 140;
    drive_frame(H * V, 1'b0, 1'b0);
    drain("post_reset_mode0_no_fs");
    fill_uniform(200);
    run_frame(3, 0, 1'b0, "post_reset_iir_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
